key_sequencer: RTL and testbench
================================

# key_sequencer

Sequencing controller for the chaotic key generator in the voice-encryption datapath. It accepts seeds from the sync/key-exchange logic and loads them into the generator. After each load it runs a fixed warm-up of discarded iterations, then serves keys to the cipher stage over a valid/ready handshake. After a programmable number of keys it forces a resync. It drives the generator's `sync_en`, `next_key_en` and `sync_state_in` and reads back its `key_out`.

## Interface
Parameters:
- `DATA_WIDTH`, 32: key/seed width; matches the generator.
- `WARMUP_CYCLES`, 16: discarded iterations after every seed load; 0 skips warm-up.
- `RESYNC_PERIOD`, 1024: keys delivered before a mandatory resync; 0 disables. Must be < 2^`CNT_WIDTH`.
- `CNT_WIDTH`, 16: width of the key and warm-up counters.

Ports:
- Clock and reset: clock `clk`; reset `rst`, synchronous, active-high.
- `clk`  in  1  clock.
- `rst`  in  1  synchronous active-high reset.
- `seed_valid`  in  1  seed offered.
- `seed_data`  in  `DATA_WIDTH`  seed value (Q4.28).
- `seed_ready`  out  1  seed can be accepted.
- `key_valid`  out  1  key available to the cipher.
- `key_data`  out  `DATA_WIDTH`  current key.
- `key_ready`  in  1  cipher consumes key.
- `gen_sync_en`  out  1  to generator `sync_en`.
- `gen_sync_state`  out  `DATA_WIDTH`  to generator `sync_state_in`.
- `gen_next_key_en`  out  1  to generator `next_key_en`.
- `gen_key_in`  in  `DATA_WIDTH`  from generator `key_out`.
- `resync_req`  out  1  period expired; upstream must supply a new seed.
- `busy`  out  1  loading or warming up.
- `keys_issued`  out  `CNT_WIDTH`  keys delivered since last seed load.

## Operation
FSM states are IDLE, LOAD, WARMUP, RUN and RESYNC_WAIT.
- **Reset:** state goes to IDLE. The seed register, warm-up counter and `keys_issued` clear to 0. All outputs are 0 except `seed_ready`=1.
- **Seed acceptance:** `seed_ready`=1 in IDLE, RUN and RESYNC_WAIT; 0 in LOAD and WARMUP. When `seed_valid`&&`seed_ready`, `seed_data` is registered and the FSM goes to LOAD.
- **LOAD (1 cycle):**
  - `gen_sync_en`=1, with `gen_sync_state` driven from the registered seed.
  - `keys_issued` clears to 0.
  - Next state is WARMUP if `WARMUP_CYCLES`>0, else RUN.
- **WARMUP:**
  - `gen_next_key_en`=1 every cycle for exactly `WARMUP_CYCLES` cycles (down-counter loaded with `WARMUP_CYCLES`-1).
  - Goes to RUN after the count reaches 0.
- **RUN:**
  - `key_valid`=1, and `key_data`=`gen_key_in` (combinational pass-through).
  - On a handshake (`key_valid`&&`key_ready`): `gen_next_key_en`=1 in the same cycle (combinational from `key_ready`), and `keys_issued` increments, wrapping modulo 2^`CNT_WIDTH`.
  - If `RESYNC_PERIOD`≠0 and the handshake brings the period count to `RESYNC_PERIOD`, the FSM goes to RESYNC_WAIT.
- **RESYNC_WAIT:** `resync_req`=1 and `key_valid`=0 until a seed is accepted, then LOAD.
- `busy`=1 in LOAD and WARMUP.
- **Invariant:** `gen_sync_en` and `gen_next_key_en` are never both 1.
- **Rekey in RUN** (seed accepted while in RUN):
  - A key handshake in the same cycle still completes: count increments and `gen_next_key_en` pulses.
  - The FSM then goes to LOAD, and `key_valid` drops without a handshake. This is the only case where an un-consumed key may be withdrawn.
- **Backpressure:** while `key_ready`=0, `key_data` stays stable (the generator does not advance) and no pulses are issued.
- **Reset mid-operation:** the FSM returns to IDLE at the next edge and all pulses stop. The generator shares `rst` and reinitialises in the same cycle.

## Timing
- Seed accepted at edge T:
  - `gen_sync_en` is high in cycle T+1.
  - Warm-up pulses occur in cycles T+2 … T+1+W, where W=`WARMUP_CYCLES`.
  - `key_valid` rises in cycle T+2+W, with `key_data` equal to the generator state after W iterations.
  - With W=0, `key_valid` rises in T+2 and the first key is the seed itself.
- RUN throughput: one key per cycle when `key_ready` is held high. The next key is visible the cycle after each handshake.
- `resync_req` asserts in the cycle after the `RESYNC_PERIOD`-th handshake.
- All state and counters are registered. `gen_next_key_en` is combinational in RUN and registered-state decoded in WARMUP.

## Structure
- Shared package `chaos_pkg` holds:
  - the FSM state encoding localparams (3 bits);
  - Q4.28 constants: `ONE`=0x10000000 and the reset seed 0x01F97414.
- No sub-module: the FSM and two counters stay inline. The generator is instantiated alongside it one level up, in the key-path top.

## Test plan
Bench uses `WARMUP_CYCLES`=4 and `RESYNC_PERIOD`=3 unless stated otherwise.
1. Release `rst` → `seed_ready`=1, `key_valid`=0, `busy`=0, `keys_issued`=0, `gen_sync_en`=`gen_next_key_en`=0.
2. Seed 0x01F97414 accepted at T → `gen_sync_en`=1 with `gen_sync_state`=0x01F97414 at T+1; `gen_next_key_en` high T+2..T+5 (4 pulses); `key_valid`=1 at T+6; `key_data` matches the reference model after 4 iterations.
3. `key_ready` held 1 → 3 consecutive keys, `keys_issued`=3, then `key_valid`=0 and `resync_req`=1. New seed → `resync_req`=0 next cycle, `keys_issued`=0 after LOAD.
4. `key_ready`=0 for 5 cycles in RUN → `key_valid` stays 1, `key_data` unchanged, zero `gen_next_key_en` pulses.
5. Seed offered in RUN in the same cycle as a key handshake → `keys_issued` increments, `gen_next_key_en` pulses once, `gen_sync_en` high the next cycle, never both high together.
6. `rst` asserted during the second warm-up cycle → state IDLE next cycle, no further pulses, `seed_ready`=1.

Source files
------------

// File: rtl/chaos_pkg.sv
// Shared definitions for the chaotic key path: FSM encoding and Q4.28 constants.
package chaos_pkg;

  localparam logic [2:0] ST_IDLE        = 3'd0;
  localparam logic [2:0] ST_LOAD        = 3'd1;
  localparam logic [2:0] ST_WARMUP      = 3'd2;
  localparam logic [2:0] ST_RUN         = 3'd3;
  localparam logic [2:0] ST_RESYNC_WAIT = 3'd4;

  typedef enum logic [2:0] {
    IDLE        = ST_IDLE,
    LOAD        = ST_LOAD,
    WARMUP      = ST_WARMUP,
    RUN         = ST_RUN,
    RESYNC_WAIT = ST_RESYNC_WAIT
  } seq_state_t;

  // Q4.28 fixed point
  localparam logic [31:0] ONE        = 32'h1000_0000;
  localparam logic [31:0] RESET_SEED = 32'h01F9_7414;

endpackage

// File: rtl/key_sequencer.sv
// Seeds the chaotic generator, runs its warm-up, then serves keys to the cipher
// over valid/ready until the resync period forces a fresh seed.
module key_sequencer
  import chaos_pkg::*;
#(
  parameter int DATA_WIDTH    = 32,
  parameter int WARMUP_CYCLES = 16,
  parameter int RESYNC_PERIOD = 1024,
  parameter int CNT_WIDTH     = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  seed_valid,
  input  logic [DATA_WIDTH-1:0] seed_data,
  output logic                  seed_ready,
  output logic                  key_valid,
  output logic [DATA_WIDTH-1:0] key_data,
  input  logic                  key_ready,
  output logic                  gen_sync_en,
  output logic [DATA_WIDTH-1:0] gen_sync_state,
  output logic                  gen_next_key_en,
  input  logic [DATA_WIDTH-1:0] gen_key_in,
  output logic                  resync_req,
  output logic                  busy,
  output logic [CNT_WIDTH-1:0]  keys_issued
);

  localparam bit HAS_WARMUP = (WARMUP_CYCLES > 0);
  localparam bit HAS_RESYNC = (RESYNC_PERIOD != 0);
  localparam logic [CNT_WIDTH-1:0] WARM_INIT =
    HAS_WARMUP ? CNT_WIDTH'(WARMUP_CYCLES - 1) : '0;
  localparam logic [CNT_WIDTH-1:0] PERIOD = CNT_WIDTH'(RESYNC_PERIOD);

  seq_state_t            state, state_nxt;
  logic [DATA_WIDTH-1:0] seed_q;
  logic [CNT_WIDTH-1:0]  warm_cnt;
  logic                  seed_acc, key_hs, period_hit;

  assign seed_acc       = seed_valid & seed_ready;
  assign key_hs         = key_valid & key_ready;
  assign period_hit     = HAS_RESYNC && ((keys_issued + CNT_WIDTH'(1)) == PERIOD);
  assign gen_sync_state = seed_q;

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // A seed arriving in RUN takes priority over a resync triggered by the same handshake.
  always_comb begin
    state_nxt       = state;
    seed_ready      = 1'b0;
    key_valid       = 1'b0;
    key_data        = '0;
    gen_sync_en     = 1'b0;
    gen_next_key_en = 1'b0;
    resync_req      = 1'b0;
    busy            = 1'b0;
    case (state)
      IDLE: begin
        seed_ready = 1'b1;
        if (seed_valid) state_nxt = LOAD;
      end
      LOAD: begin
        busy        = 1'b1;
        gen_sync_en = 1'b1;
        state_nxt   = HAS_WARMUP ? WARMUP : RUN;
      end
      WARMUP: begin
        busy            = 1'b1;
        gen_next_key_en = 1'b1;
        if (warm_cnt == '0) state_nxt = RUN;
      end
      RUN: begin
        seed_ready      = 1'b1;
        key_valid       = 1'b1;
        key_data        = gen_key_in;
        gen_next_key_en = key_ready;
        if (seed_valid)                    state_nxt = LOAD;
        else if (key_ready && period_hit)  state_nxt = RESYNC_WAIT;
      end
      RESYNC_WAIT: begin
        seed_ready = 1'b1;
        resync_req = 1'b1;
        if (seed_valid) state_nxt = LOAD;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      seed_q      <= '0;
      warm_cnt    <= '0;
      keys_issued <= '0;
    end else begin
      if (seed_acc) seed_q <= seed_data;
      if (state == LOAD)                            warm_cnt <= WARM_INIT;
      else if (state == WARMUP && warm_cnt != '0)   warm_cnt <= warm_cnt - CNT_WIDTH'(1);
      if (state == LOAD)  keys_issued <= '0;
      else if (key_hs)    keys_issued <= keys_issued + CNT_WIDTH'(1);
    end
  end

endmodule

// File: tb/tb_key_sequencer.sv
// Scoreboard bench for key_sequencer with a behavioural stand-in for the chaotic generator.
module tb_key_sequencer;
  import chaos_pkg::*;

  localparam int DW = 32;
  localparam int W  = 4;
  localparam int P  = 3;
  localparam int CW = 16;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          seed_valid = 1'b0;
  logic [DW-1:0] seed_data = '0;
  logic          seed_ready;
  logic          key_valid;
  logic [DW-1:0] key_data;
  logic          key_ready = 1'b0;
  logic          gen_sync_en;
  logic [DW-1:0] gen_sync_state;
  logic          gen_next_key_en;
  logic [DW-1:0] gen_key_in;
  logic          resync_req;
  logic          busy;
  logic [CW-1:0] keys_issued;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  key_sequencer #(.DATA_WIDTH(DW), .WARMUP_CYCLES(W), .RESYNC_PERIOD(P), .CNT_WIDTH(CW)) dut (
    .clk(clk), .rst(rst), .seed_valid(seed_valid), .seed_data(seed_data), .seed_ready(seed_ready),
    .key_valid(key_valid), .key_data(key_data), .key_ready(key_ready),
    .gen_sync_en(gen_sync_en), .gen_sync_state(gen_sync_state), .gen_next_key_en(gen_next_key_en),
    .gen_key_in(gen_key_in), .resync_req(resync_req), .busy(busy), .keys_issued(keys_issued)
  );

  // Stand-in generator iteration; any deterministic map works for sequencing checks.
  function automatic logic [31:0] step(input logic [31:0] x);
    return x * 32'd1664525 + 32'd1013904223;
  endfunction

  function automatic logic [31:0] iter(input logic [31:0] x, input int n);
    logic [31:0] v = x;
    for (int i = 0; i < n; i++) v = step(v);
    return v;
  endfunction

  logic [DW-1:0] gen_state;
  always @(posedge clk) begin
    if (rst)                  gen_state <= RESET_SEED;
    else if (gen_sync_en)     gen_state <= gen_sync_state;
    else if (gen_next_key_en) gen_state <= step(gen_state);
  end
  assign gen_key_in = gen_state;

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", nm, got, exp, $time);
    end
  endtask

  // Reference model: phase since last accepted seed plus a queue of keys still owed.
  bit            trk = 1'b0;
  int            p = 0;
  int            kcount = 0;
  logic [31:0]   cur_seed = '0;
  logic [31:0]   q[$];
  bit            exp_sr, exp_kv, hs;

  always @(negedge clk) begin
    if (trk) p++;
    exp_sr = !(trk && p >= 1 && p <= W + 1);
    exp_kv = trk && p >= W + 2 && q.size() > 0;
    hs     = exp_kv && key_ready;
    chk("seed_ready", 32'(seed_ready), 32'(exp_sr));
    chk("busy", 32'(busy), 32'(!exp_sr));
    chk("gen_sync_en", 32'(gen_sync_en), 32'(trk && p == 1));
    if (trk && p == 1) chk("gen_sync_state", gen_sync_state, cur_seed);
    chk("gen_next_key_en", 32'(gen_next_key_en), 32'((trk && p >= 2 && p <= W + 1) || hs));
    chk("key_valid", 32'(key_valid), 32'(exp_kv));
    if (exp_kv) chk("key_data", key_data, q[0]);
    chk("resync_req", 32'(resync_req), 32'(trk && p >= W + 2 && q.size() == 0));
    chk("keys_issued", 32'(keys_issued), 32'(kcount));
    chk("pulse_exclusive", 32'(gen_sync_en & gen_next_key_en), 32'd0);
    if (hs) begin
      void'(q.pop_front());
      kcount = (kcount + 1) % (1 << CW);
    end
    if (trk && p == 1) kcount = 0;
    if (rst) begin
      trk = 1'b0;
      q.delete();
      kcount = 0;
    end else if (seed_valid && exp_sr) begin
      trk = 1'b1;
      p = 0;
      cur_seed = seed_data;
      q.delete();
      for (int i = 0; i < P; i++) q.push_back(iter(seed_data, W + i));
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [31:0] s2, s3;
    bit seen;

    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("reset_seed_ready", 32'(seed_ready), 32'd1);
    chk("reset_key_valid", 32'(key_valid), 32'd0);
    chk("reset_keys_issued", 32'(keys_issued), 32'd0);

    // Reset seed, key_ready held high: three keys then resync.
    @(posedge clk); #1;
    seed_valid = 1'b1; seed_data = RESET_SEED; key_ready = 1'b1;
    @(posedge clk); #1;
    seed_valid = 1'b0;
    seen = 1'b0;
    for (int n = 0; n < 40 && !seen; n++) begin
      @(negedge clk);
      seen = resync_req;
    end
    chk("resync_reached", 32'(seen), 32'd1);
    chk("resync_keys_issued", 32'(keys_issued), 32'(P));
    chk("resync_key_valid", 32'(key_valid), 32'd0);

    // New seed under backpressure.
    s2 = $urandom;
    @(posedge clk); #1;
    seed_valid = 1'b1; seed_data = s2; key_ready = 1'b0;
    @(posedge clk); #1;
    seed_valid = 1'b0;
    @(negedge clk);
    chk("resync_req_drop", 32'(resync_req), 32'd0);
    seen = 1'b0;
    for (int n = 0; n < 40 && !seen; n++) begin
      @(negedge clk);
      seen = key_valid;
    end
    chk("key_valid_reached", 32'(seen), 32'd1);
    for (int n = 0; n < 5; n++) begin
      chk("bp_key_valid", 32'(key_valid), 32'd1);
      chk("bp_key_data", key_data, iter(s2, W));
      chk("bp_no_pulse", 32'(gen_next_key_en), 32'd0);
      @(negedge clk);
    end

    // Rekey in RUN with a simultaneous key handshake.
    s3 = $urandom;
    @(posedge clk); #1;
    key_ready = 1'b1; seed_valid = 1'b1; seed_data = s3;
    @(negedge clk);
    chk("rekey_pulse", 32'(gen_next_key_en), 32'd1);
    chk("rekey_no_sync", 32'(gen_sync_en), 32'd0);
    chk("rekey_key", key_data, iter(s2, W));
    @(posedge clk); #1;
    seed_valid = 1'b0; key_ready = 1'b0;
    @(negedge clk);
    chk("rekey_sync_en", 32'(gen_sync_en), 32'd1);
    chk("rekey_sync_state", gen_sync_state, s3);
    chk("rekey_keys_issued", 32'(keys_issued), 32'd1);

    // Reset during the second warm-up cycle.
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b1;
    @(negedge clk);
    chk("rst_warm_pulse", 32'(gen_next_key_en), 32'd1);
    @(posedge clk); #1;
    rst = 1'b0;
    for (int n = 0; n < 3; n++) begin
      @(negedge clk);
      chk("rst_no_pulse", 32'(gen_next_key_en), 32'd0);
      chk("rst_seed_ready", 32'(seed_ready), 32'd1);
      chk("rst_busy", 32'(busy), 32'd0);
    end

    // Randomized traffic; the model checks every cycle.
    for (int n = 0; n < 600; n++) begin
      @(posedge clk); #1;
      key_ready  = ($urandom_range(0, 3) != 0);
      seed_valid = ($urandom_range(0, 11) == 0);
      seed_data  = $urandom;
    end
    @(posedge clk); #1;
    seed_valid = 1'b0; key_ready = 1'b0;
    repeat (4) @(posedge clk);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
